stream_recv_ctrl: RTL
=====================

// Module: stream_recv_ctrl
// PURPOSE
//  Input-side AXI4-Stream receiver controller: accepts DMA beats (src_valid/src_ready/src_last),
//  writes each beat into local buffer memory with a running address, pulses recv_fin once the
//  frame is stored. Counterpart of the output-side stream transmitter; recv_fin feeds compute start.
// PARAMETERS
//  DW  32  stream/memory data width (bits)
//  AW  8   buffer address width; frame holds at most 2**AW words
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous active-high reset
//  start      in   1   1-cycle pulse: arm receive of one frame (ignored while busy)
//  fin        in   AW  index of last expected word (frame length - 1), sampled at start
//  en         in   1   downstream gate; 0 pauses acceptance (src_ready forced 0)
//  src_valid  in   1   AXIS TVALID
//  src_data   in   DW  AXIS TDATA
//  src_last   in   1   AXIS TLAST
//  src_ready  out  1   AXIS TREADY (combinational from state and en)
//  mem_we     out  1   buffer write enable (registered)
//  mem_addr   out  AW  buffer write address (registered)
//  mem_wdata  out  DW  buffer write data (registered)
//  recv_busy  out  1   state != IDLE
//  recv_fin   out  1   1-cycle pulse: frame fully written (registered)
//  err_len    out  1   sticky: TLAST position != fin; cleared by accepted start or rst
// BEHAVIOUR
//  - Reset (sync, all regs): state=IDLE, cnt=0, fin_q=0, mem_we=0, mem_addr=0, mem_wdata=0,
//    recv_fin=0, err_len=0. src_ready=0 and recv_busy=0 follow from state.
//  - acc = src_valid & src_ready. FSM:
//    IDLE : src_ready=0. start -> RECV; fin_q<=fin, cnt<=0, err_len<=0.
//    RECV : src_ready=en. On acc: mem_we<=1, mem_addr<=cnt, mem_wdata<=src_data, cnt<=cnt+1.
//           acc & src_last & cnt==fin_q            -> DONE (good frame).
//           acc & src_last & cnt< fin_q            -> DONE, err_len<=1 (short frame; rest unwritten).
//           acc & !src_last & cnt==fin_q           -> FLUSH, err_len<=1 (long frame; word is written).
//    FLUSH: src_ready=en; beats accepted and discarded (mem_we=0); acc & src_last -> DONE.
//    DONE : src_ready=0; recv_fin<=1 for exactly one cycle; -> IDLE.
//  - Latency: beat accepted at cycle T -> mem_we/addr/wdata visible T+1. Final beat at T ->
//    final write T+1 (state DONE), recv_fin=1 at T+2 (state IDLE, busy=0 same cycle).
//  - mem_we=0 in any cycle without acc in RECV; mem_addr/mem_wdata hold last value.
//  - cnt is AW bits, never wraps in RECV (cnt==fin_q exits); fin=2**AW-1 gives full buffer.
//  - fin=0: one-word frame; first beat must carry src_last, else FLUSH + err_len.
//  - en low mid-frame: src_ready drops same cycle, no beat lost or duplicated; cnt holds.
//  - start while recv_busy: ignored (fin_q, cnt, err_len unchanged).
//  - start in same cycle as recv_fin pulse (state IDLE): accepted normally.
//  - rst mid-frame: abort; outputs to reset values next cycle; no recv_fin; partial data stale.
// TESTING
//  1 start fin=3, 4 beats D0..D3 back-to-back, TLAST on D3 -> writes addr 0..3 on T+1..T+4,
//    recv_fin single pulse 2 cycles after D3 accept, err_len=0, busy=0 with recv_fin.
//  2 same frame, en toggled 0 for 3 cycles after beat 1 and src_valid random -> src_ready=0
//    exactly while en=0, addresses 0..3 contiguous, data in order, no duplicate writes.
//  3 fin=3, TLAST on beat 2 -> writes addr 0..2 only, recv_fin pulses, err_len=1 until next start.
//  4 fin=1, 5 beats TLAST on beat 4 -> writes addr 0..1, beats 2..4 accepted without mem_we,
//    recv_fin after beat 4, err_len=1; next start clears err_len.
//  5 start pulsed at frame word 2 with fin=7 -> ignored, frame ends at original fin.
//  6 rst asserted after 2 of 4 beats -> next cycle state IDLE, src_ready=0, mem_we=0,
//    recv_fin never pulses; subsequent start fin=0 single-beat frame completes at addr 0.

Source files
------------

// File: rtl/stream_recv_if.sv
// AXI4-Stream handshake bundle between a DMA source and the receive controller.
interface stream_recv_if #(
    parameter int DW = 32
);
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_last;
    logic          src_ready;

    modport master (
        output src_valid,
        output src_data,
        output src_last,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        input  src_last,
        output src_ready
    );
endinterface

// File: rtl/stream_recv_ctrl.sv
// Input-side stream receiver: stores one frame of beats into a local buffer and
// pulses recv_fin once the last word has been written.
module stream_recv_ctrl #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] fin,
    input  logic          en,
    stream_recv_if.slave  src,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          recv_busy,
    output logic          recv_fin,
    output logic          err_len
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] fin_q_r;
    logic          acc_s;

    // Ready only while a frame is open; en pauses the source without losing beats.
    assign src.src_ready = ((state_r == RECV) || (state_r == FLUSH)) ? en : 1'b0;
    assign acc_s         = src.src_valid & src.src_ready;
    assign recv_busy     = (state_r != IDLE);

    // Receive FSM with registered buffer-write and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            fin_q_r   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            recv_fin  <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            recv_fin <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RECV;
                        fin_q_r <= fin;
                        cnt_r   <= '0;
                        err_len <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RECV: begin
                    if (acc_s) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt_r;
                        mem_wdata <= src.src_data;
                        // Wraps only on the exit beat of a full-buffer frame, so it is harmless.
                        cnt_r     <= cnt_r + AW'(1);
                        if (src.src_last) begin
                            state_r <= DONE;
                            if (cnt_r != fin_q_r) begin
                                err_len <= 1'b1;
                            end else begin
                                err_len <= err_len;
                            end
                        end else if (cnt_r == fin_q_r) begin
                            state_r <= FLUSH;
                            err_len <= 1'b1;
                        end else begin
                            state_r <= RECV;
                        end
                    end else begin
                        state_r <= RECV;
                    end
                end
                FLUSH: begin
                    if (acc_s && src.src_last) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= FLUSH;
                    end
                end
                DONE: begin
                    recv_fin <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
